// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around mem_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter for one memory port,
// one outstanding transaction, LSU priority with an IFU anti-starvation streak limit.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int MASK_W   = DATA_W / 8;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t              state;
    logic                owner_lsu;
    logic [STREAK_W-1:0] streak;

    logic              mem_req_valid_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wen_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [MASK_W-1:0] mem_wmask_r;
    logic              ifu_resp_valid_r;
    logic              lsu_resp_valid_r;
    logic [DATA_W-1:0] ifu_rdata_r;
    logic [DATA_W-1:0] lsu_rdata_r;

    logic at_max;
    logic lsu_win;
    logic ifu_win;

    // LSU has priority until it has won MAX_LSU_STREAK times in a row over a waiting IFU.
    always_comb begin
        at_max  = (streak == STREAK_W'(MAX_LSU_STREAK));
        lsu_win = bus.lsu_req_valid && !(bus.ifu_req_valid && at_max);
        ifu_win = bus.ifu_req_valid && !lsu_win;
    end

    assign bus.ifu_req_ready  = !rst && (state == IDLE) && ifu_win;
    assign bus.lsu_req_ready  = !rst && (state == IDLE) && lsu_win;
    assign bus.mem_req_valid  = mem_req_valid_r;
    assign bus.mem_addr       = mem_addr_r;
    assign bus.mem_wen        = mem_wen_r;
    assign bus.mem_wdata      = mem_wdata_r;
    assign bus.mem_wmask      = mem_wmask_r;
    assign bus.ifu_resp_valid = ifu_resp_valid_r;
    assign bus.lsu_resp_valid = lsu_resp_valid_r;
    assign bus.ifu_rdata      = ifu_rdata_r;
    assign bus.lsu_rdata      = lsu_rdata_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            owner_lsu        <= 1'b0;
            streak           <= '0;
            mem_req_valid_r  <= 1'b0;
            mem_addr_r       <= '0;
            mem_wen_r        <= 1'b0;
            mem_wdata_r      <= '0;
            mem_wmask_r      <= '0;
            ifu_resp_valid_r <= 1'b0;
            lsu_resp_valid_r <= 1'b0;
            ifu_rdata_r      <= '0;
            lsu_rdata_r      <= '0;
        end else begin
            ifu_resp_valid_r <= 1'b0;
            lsu_resp_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_win) begin
                        owner_lsu       <= 1'b1;
                        mem_addr_r      <= bus.lsu_addr;
                        mem_wen_r       <= bus.lsu_wen;
                        mem_wdata_r     <= bus.lsu_wdata;
                        mem_wmask_r     <= bus.lsu_wmask;
                        mem_req_valid_r <= 1'b1;
                        state           <= REQ;
                        // Only LSU wins that make the IFU wait count toward the streak.
                        if (!bus.ifu_req_valid)
                            streak <= '0;
                        else if (streak != {STREAK_W{1'b1}} && !at_max)
                            streak <= streak + STREAK_W'(1);
                    end else if (ifu_win) begin
                        owner_lsu       <= 1'b0;
                        mem_addr_r      <= bus.ifu_addr;
                        mem_wen_r       <= 1'b0;
                        mem_wdata_r     <= '0;
                        mem_wmask_r     <= '0;
                        mem_req_valid_r <= 1'b1;
                        state           <= REQ;
                        streak          <= '0;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        if (owner_lsu) begin
                            lsu_rdata_r      <= bus.mem_rdata;
                            lsu_resp_valid_r <= 1'b1;
                        end else begin
                            ifu_rdata_r      <= bus.mem_rdata;
                            ifu_resp_valid_r <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks, a delay-programmable memory
// model and a response monitor popping expected completions.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LSU_STREAK(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          lsu;
        bit          chk_data;
        logic [31:0] data;
        int          acc_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    bit   grant_log[$];
    int   acc_log[$];

    int n_checks = 0;
    int n_err    = 0;
    int exp_lat  = 0;

    int ready_dly = 0;
    int resp_dly  = 0;
    bit stray     = 0;
    int mstate    = 0;
    bit busy      = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // Called on a falling edge; returns on a falling edge after the accept.
    task automatic ifu_read(input logic [31:0] a);
        bit ok = 0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = a;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.ifu_req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check_eq("ifu_accept_timeout", 1, 0);
            bus.ifu_req_valid = 1'b0;
            return;
        end
        exp_q.push_back('{lsu: 1'b0, chk_data: 1'b1, data: mem_data(a), acc_cyc: cyc, lat: exp_lat});
        req_q.push_back('{addr: a, wen: 1'b0, wdata: 32'h0, wmask: 4'h0});
        grant_log.push_back(1'b0);
        acc_log.push_back(cyc);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_op(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                          input logic [3:0] wm);
        bit ok = 0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = a;
        bus.lsu_wen       = wen;
        bus.lsu_wdata     = wd;
        bus.lsu_wmask     = wm;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.lsu_req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check_eq("lsu_accept_timeout", 1, 0);
            bus.lsu_req_valid = 1'b0;
            return;
        end
        exp_q.push_back('{lsu: 1'b1, chk_data: !wen, data: mem_data(a), acc_cyc: cyc, lat: exp_lat});
        req_q.push_back('{addr: a, wen: wen, wdata: wd, wmask: wm});
        grant_log.push_back(1'b1);
        acc_log.push_back(cyc);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && mstate == 0) begin ok = 1; break; end
        end
        if (!ok) check_eq("completion_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Memory model: programmable accept and response delays, checks the issued payload.
    initial begin
        int   cnt;
        int   rcnt;
        logic [31:0] cur_addr;
        req_t r;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        cnt = 0; rcnt = 0; cur_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (rst) begin
                mstate = 0;
            end else begin
                if (stray) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = 32'hBAD0_BAD0;
                    stray = 0;
                end
                if (mstate == 0 && bus.mem_req_valid) begin
                    cnt    = ready_dly;
                    mstate = 1;
                end
                if (mstate == 1) begin
                    if (req_q.size() == 0) begin
                        check_eq("mem_req_unexpected", 1, 0);
                        mstate = 0;
                    end else begin
                        r = req_q[0];
                        check_eq("mem_req_valid_held", bus.mem_req_valid, 1);
                        check_eq("mem_addr", bus.mem_addr, r.addr);
                        check_eq("mem_wen", bus.mem_wen, r.wen);
                        check_eq("mem_wdata", bus.mem_wdata, r.wdata);
                        check_eq("mem_wmask", bus.mem_wmask, r.wmask);
                        if (cnt == 0) begin
                            bus.mem_req_ready = 1'b1;
                            cur_addr = bus.mem_addr;
                            void'(req_q.pop_front());
                            rcnt   = resp_dly;
                            mstate = 2;
                        end else begin
                            cnt--;
                        end
                    end
                end else if (mstate == 2) begin
                    if (rcnt == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_rdata      = mem_data(cur_addr);
                        mstate = 0;
                    end else begin
                        rcnt--;
                    end
                end
            end
        end
    end

    // Response and grant monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                busy = 0;
            end else begin
                if (bus.ifu_resp_valid && bus.lsu_resp_valid)
                    check_eq("two_resp", 1, 0);
                if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("resp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("resp_owner_lsu", bus.lsu_resp_valid, e.lsu);
                        if (e.chk_data)
                            check_eq("resp_rdata", e.lsu ? bus.lsu_rdata : bus.ifu_rdata, e.data);
                        if (e.lat != 0)
                            check_eq("resp_latency", cyc - e.acc_cyc, e.lat);
                    end
                    busy = 0;
                end
                if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                    check_eq("one_ready", bus.ifu_req_ready & bus.lsu_req_ready, 0);
                    check_eq("grant_while_busy", busy, 0);
                    busy = 1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req_valid", bus.mem_req_valid, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wen", bus.mem_wen, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_mem_wmask", bus.mem_wmask, 0);
        check_eq("rst_resp_valids", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        check_eq("rst_rdatas", {bus.ifu_rdata, bus.lsu_rdata}, 0);
        check_eq("rst_readys", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single IFU read at minimum latency.
        ready_dly = 0; resp_dly = 0; exp_lat = 3;
        ifu_read(32'h8000_0000);
        wait_done();

        // LSU write held through three stalled cycles, then an LSU read.
        ready_dly = 3; exp_lat = 6;
        lsu_op(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        wait_done();
        ready_dly = 0; exp_lat = 3;
        lsu_op(32'h8000_2004, 1'b0, 32'h0, 4'h0);
        wait_done();

        // Contention: both requesters continuously valid.
        exp_lat = 0;
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) ifu_read(32'h8000_0100 + 32'(4 * i));
            for (int j = 0; j < 12; j++) lsu_op(32'h8000_3000 + 32'(4 * j), 1'b0, 32'h0, 4'h0);
        join
        wait_done();
        check_eq("contention_grants", grant_log.size(), 15);
        for (int k = 0; k < grant_log.size(); k++)
            check_eq($sformatf("grant_order_%0d", k), grant_log[k], (k % (MAXS + 1)) != MAXS);

        // Slow memory: response 10 cycles after accept, LSU request pending meanwhile.
        ready_dly = 0; resp_dly = 8; exp_lat = 11;
        fork
            ifu_read(32'h8000_0200);
            begin
                repeat (2) @(negedge clk);
                lsu_op(32'h8000_4000, 1'b0, 32'h0, 4'h0);
            end
        join
        wait_done();

        // Reset while waiting for the response, then a stray response.
        resp_dly = 30; exp_lat = 0;
        ifu_read(32'h8000_0300);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        req_q.delete();
        @(negedge clk);
        rst   = 1'b0;
        stray = 1;
        #3;
        check_eq("post_rst_mem_req_valid", bus.mem_req_valid, 0);
        check_eq("post_rst_resp_valids", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        repeat (5) @(negedge clk);
        resp_dly = 0; exp_lat = 3;
        ifu_read(32'h8000_0400);
        wait_done();

        // Back-to-back IFU reads against zero-latency memory.
        acc_log.delete();
        fork
            for (int i = 0; i < 5; i++) ifu_read(32'h8000_0500 + 32'(4 * i));
        join
        wait_done();
        check_eq("b2b_accepts", acc_log.size(), 5);
        for (int k = 1; k < acc_log.size(); k++)
            check_eq($sformatf("b2b_spacing_%0d", k), acc_log[k] - acc_log[k-1], 4);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Accepts one request at a time from either side and issues it to memory with a valid/ready handshake.
- Waits for the memory response and routes it back to the requester that owns the transaction.
- Sits between the fetch/LSU stages and the memory model; it replaces direct per-stage memory access.

Parameters:
- ADDR_W, 32, address width of all request ports.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.
- MAX_LSU_STREAK, 4, max consecutive LSU grants while IFU is waiting before IFU is forced a grant (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU request present
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  one-cycle pulse, ifu_rdata valid
- ifu_rdata  out  DATA_W  fetched instruction word
- lsu_req_valid  in  1  LSU request present
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write enables
- lsu_resp_valid  out  1  one-cycle pulse, completion (read data valid when read)
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write flag (0 for IFU)
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  DATA_W/8  registered mask (all zero for IFU)
- mem_resp_valid  in  1  memory response present (one cycle)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. One outstanding transaction max.
- Reset: state=IDLE, owner=IFU, streak=0. All valid/ready outputs 0; mem_addr/wdata/wmask/wen and both rdata outputs 0.
- IDLE, arbitration (combinational from the valids):
  - LSU wins if lsu_req_valid, unless ifu_req_valid and streak==MAX_LSU_STREAK; then IFU wins.
  - Only one of ifu_req_ready/lsu_req_ready is high, and only in IDLE with the matching valid high.
  - On grant: latch payload and owner into mem_* registers, go REQ.
  - Streak update: LSU grant while ifu_req_valid → streak+1 (saturating). IFU grant → streak=0. LSU grant with IFU not waiting → streak=0.
- REQ: mem_req_valid=1 with payload held stable. On mem_req_ready, go RESP and drop mem_req_valid the next cycle.
- RESP: wait any number of cycles. On mem_resp_valid, capture mem_rdata into the owner's rdata register, go DONE.
  - mem_resp_valid in any state other than RESP is ignored.
- DONE: the owner's resp_valid=1 for exactly one cycle, the other side's resp_valid=0. Go IDLE.
  - rdata outputs hold their last value until the next capture.
- Requesters receive no back-pressure on responses; they must consume the pulse.
- Minimum latency, accept at cycle T with mem_req_ready at T+1 and mem_resp_valid at T+2: mem_req_valid at T+1, resp_valid at T+3, next accept possible at T+4.
- Requesters must hold valid and payload until ready. The arbiter samples payload only in the grant cycle.
- For LSU writes the memory still returns mem_resp_valid; lsu_resp_valid signals completion and lsu_rdata is don't-care.
- Reset mid-operation: transaction abandoned, next cycle state=IDLE and all valids low, no response delivered. A late mem_resp_valid after reset is ignored.
- Simultaneous IFU+LSU valid with streak<MAX: LSU granted, IFU stays pending with ready=0.

Test Plan:
- Single IFU read: ifu_addr=0x80000000, mem ready at T+1, resp 0x00000413 at T+2 → ifu_resp_valid pulse at T+3 with ifu_rdata=0x00000413, lsu_resp_valid stays 0.
- LSU write: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF → mem_wen=1, mem_wmask=0xF held through 3 cycles of mem_req_ready=0; lsu_resp_valid once after mem_resp_valid.
- Contention, MAX_LSU_STREAK=4, both valid continuously → grant order LSU,LSU,LSU,LSU,IFU,LSU…; never two ready signals in one cycle.
- Slow memory: mem_resp_valid 10 cycles after accept → FSM stays RESP; no new grants; exactly one resp pulse.
- Reset asserted in RESP, then stray mem_resp_valid next cycle → no resp_valid on either side; IDLE; next IFU request served normally.
- Back-to-back IFU requests with zero-latency memory → accepts spaced 4 cycles apart; each rdata matches its address.
